// File: rtl/mem_port_arbiter.sv
// Two-client arbiter sharing one slow block-memory port between the I-cache and D-cache.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is fixed D-priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

    state_t            state, state_nxt;
    logic              req_i, req_d, pick_d, grant, done;
    logic              owner_d;
    logic [DATA_W-1:0] rbuf;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;
    assign grant = (state == IDLE) && (req_i || req_d);
    assign done  = ((state == GNT_I) || (state == GNT_D)) && mem_ready;

`ifdef ARB_RR_EN
    // last_d = 0 means I was granted last (reset value)
    logic last_d;
    assign pick_d = req_d && (!req_i || !last_d);

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset)
            last_d <= 1'b0;
        else if (grant)
            last_d <= pick_d;
    end
`else
    assign pick_d = req_d;
`endif

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (req_i || req_d) state_nxt = pick_d ? GNT_D : GNT_I;
            GNT_I, GNT_D: if (mem_ready) state_nxt = RESP;
            RESP:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_mem_ready = (state == RESP) && !owner_d;
        d_mem_ready = (state == RESP) && owner_d;
        i_mem_rdata = rbuf;
        d_mem_rdata = rbuf;
    end

    // Registered memory-side request, read buffer and completion counters
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            owner_d     <= 1'b0;
            rbuf        <= '0;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
        end else if (grant) begin
            owner_d   <= pick_d;
            mem_addr  <= pick_d ? d_mem_addr  : i_mem_addr;
            mem_wdata <= pick_d ? d_mem_wdata : i_mem_wdata;
            // a combined read+write request forwards only the write
            mem_write <= pick_d ? d_mem_write : i_mem_write;
            mem_read  <= pick_d ? (d_mem_read & ~d_mem_write) : (i_mem_read & ~i_mem_write);
        end else if (done) begin
            rbuf      <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (state == GNT_I && i_grant_cnt != {CNT_W{1'b1}})
                i_grant_cnt <= i_grant_cnt + 1'b1;
            if (state == GNT_D && d_grant_cnt != {CNT_W{1'b1}})
                d_grant_cnt <= d_grant_cnt + 1'b1;
        end
    end

endmodule
